// File: rtl/sap_control_seq.sv
// Fetch/decode/execute T-state sequencer for the 16-bit SAP datapath.
// Optional retired-instruction counter enabled by defining SAP_CTRL_INSTR_COUNT_EN.
module sap_control_seq #(
  parameter int OPC_W  = 4
`ifdef SAP_CTRL_INSTR_COUNT_EN
  , parameter int ICNT_W = 16
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [OPC_W-1:0] ir_opcode,
  input  logic             zero_flag,
  output logic             pc_out,
  output logic             pc_inc,
  output logic             pc_load,
  output logic             mar_load,
  output logic             mem_out,
  output logic             mem_write,
  output logic             ir_load,
  output logic             ir_out,
  output logic             acc_write,
  output logic             acc_lower_write,
  output logic             acc_out,
  output logic             b_load,
  output logic             alu_out,
  output logic             alu_sub,
  output logic             out_load,
  output logic             halted
`ifdef SAP_CTRL_INSTR_COUNT_EN
  , output logic [ICNT_W-1:0] instr_count
`endif
);

  localparam logic [2:0] S_F0   = 3'd0;
  localparam logic [2:0] S_F1   = 3'd1;
  localparam logic [2:0] S_E0   = 3'd2;
  localparam logic [2:0] S_E1   = 3'd3;
  localparam logic [2:0] S_E2   = 3'd4;
  localparam logic [2:0] S_HALT = 3'd5;

  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JZ  = 4'h7;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  logic [2:0] state, state_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      S_F0: state_nxt = S_F1;
      S_F1: state_nxt = S_E0;
      S_E0: begin
        case (ir_opcode)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: state_nxt = S_E1;
          OP_HLT:                         state_nxt = S_HALT;
          default:                        state_nxt = S_F0;
        endcase
      end
      S_E1:   state_nxt = (ir_opcode == OP_ADD || ir_opcode == OP_SUB) ? S_E2 : S_F0;
      S_E2:   state_nxt = S_F0;
      S_HALT: state_nxt = S_HALT;
      default: state_nxt = S_F0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)      state <= S_F0;
    else if (run) state <= state_nxt;
  end

  assign halted = (state == S_HALT);

  // Strobes are a pure decode; stalled or reset cycles drive nothing so a
  // resumed step re-issues exactly once.
  always_comb begin
    pc_out          = 1'b0;
    pc_inc          = 1'b0;
    pc_load         = 1'b0;
    mar_load        = 1'b0;
    mem_out         = 1'b0;
    mem_write       = 1'b0;
    ir_load         = 1'b0;
    ir_out          = 1'b0;
    acc_write       = 1'b0;
    acc_lower_write = 1'b0;
    acc_out         = 1'b0;
    b_load          = 1'b0;
    alu_out         = 1'b0;
    alu_sub         = 1'b0;
    out_load        = 1'b0;
    if (!rst && run) begin
      case (state)
        S_F0: begin
          pc_out   = 1'b1;
          mar_load = 1'b1;
        end
        S_F1: begin
          mem_out = 1'b1;
          ir_load = 1'b1;
          pc_inc  = 1'b1;
        end
        S_E0: begin
          case (ir_opcode)
            OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
              ir_out   = 1'b1;
              mar_load = 1'b1;
            end
            OP_LDI: begin
              ir_out          = 1'b1;
              acc_lower_write = 1'b1;
            end
            OP_JMP: begin
              ir_out  = 1'b1;
              pc_load = 1'b1;
            end
            OP_JZ: begin
              ir_out  = 1'b1;
              pc_load = zero_flag;
            end
            OP_OUT: begin
              acc_out  = 1'b1;
              out_load = 1'b1;
            end
            default: ;
          endcase
        end
        S_E1: begin
          case (ir_opcode)
            OP_LDA: begin
              mem_out   = 1'b1;
              acc_write = 1'b1;
            end
            OP_ADD, OP_SUB: begin
              mem_out = 1'b1;
              b_load  = 1'b1;
            end
            OP_STA: begin
              acc_out   = 1'b1;
              mem_write = 1'b1;
            end
            default: ;
          endcase
        end
        S_E2: begin
          if (ir_opcode == OP_ADD || ir_opcode == OP_SUB) begin
            alu_out   = 1'b1;
            acc_write = 1'b1;
            alu_sub   = (ir_opcode == OP_SUB);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SAP_CTRL_INSTR_COUNT_EN
  // An instruction retires when execute hands back to fetch; HLT goes to HALT instead.
  always_ff @(posedge clk) begin
    if (rst)
      instr_count <= '0;
    else if (run && state_nxt == S_F0 && (state == S_E0 || state == S_E1 || state == S_E2))
      instr_count <= instr_count + ICNT_W'(1);
  end
`endif

endmodule

// File: tb/tb_sap_control_seq.sv
// Self-checking bench for sap_control_seq: per-scenario tasks against a
// table-driven model of the per-instruction strobe schedule.
module tb_sap_control_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic run = 1'b0;
  logic [3:0] ir_opcode = 4'h0;
  logic zero_flag = 1'b0;
  logic pc_out, pc_inc, pc_load, mar_load, mem_out, mem_write, ir_load, ir_out;
  logic acc_write, acc_lower_write, acc_out, b_load, alu_out, alu_sub, out_load, halted;
`ifdef SAP_CTRL_INSTR_COUNT_EN
  logic [15:0] instr_count;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sap_control_seq dut (
    .clk(clk), .rst(rst), .run(run), .ir_opcode(ir_opcode), .zero_flag(zero_flag),
    .pc_out(pc_out), .pc_inc(pc_inc), .pc_load(pc_load), .mar_load(mar_load),
    .mem_out(mem_out), .mem_write(mem_write), .ir_load(ir_load), .ir_out(ir_out),
    .acc_write(acc_write), .acc_lower_write(acc_lower_write), .acc_out(acc_out),
    .b_load(b_load), .alu_out(alu_out), .alu_sub(alu_sub), .out_load(out_load),
    .halted(halted)
`ifdef SAP_CTRL_INSTR_COUNT_EN
    , .instr_count(instr_count)
`endif
  );

  localparam logic [14:0] PC_OUT    = 15'h4000;
  localparam logic [14:0] PC_INC    = 15'h2000;
  localparam logic [14:0] PC_LOAD   = 15'h1000;
  localparam logic [14:0] MAR_LOAD  = 15'h0800;
  localparam logic [14:0] MEM_OUT   = 15'h0400;
  localparam logic [14:0] MEM_WRITE = 15'h0200;
  localparam logic [14:0] IR_LOAD   = 15'h0100;
  localparam logic [14:0] IR_OUT    = 15'h0080;
  localparam logic [14:0] ACC_W     = 15'h0040;
  localparam logic [14:0] ACC_LW    = 15'h0020;
  localparam logic [14:0] ACC_OUT   = 15'h0010;
  localparam logic [14:0] B_LOAD    = 15'h0008;
  localparam logic [14:0] ALU_OUT   = 15'h0004;
  localparam logic [14:0] ALU_SUB   = 15'h0002;
  localparam logic [14:0] OUT_LOAD  = 15'h0001;
  localparam logic [14:0] BUS_MASK  = PC_OUT | MEM_OUT | IR_OUT | ACC_OUT | ALU_OUT;

  logic [14:0] obs;
  assign obs = {pc_out, pc_inc, pc_load, mar_load, mem_out, mem_write, ir_load, ir_out,
                acc_write, acc_lower_write, acc_out, b_load, alu_out, alu_sub, out_load};

  // Model: cycle count of each instruction, fetch included.
  function automatic int exp_len(input logic [3:0] op);
    case (op)
      4'h1, 4'h4: return 4;
      4'h2, 4'h3: return 5;
      default:    return 3;
    endcase
  endfunction

  // Model: strobes expected in cycle idx of an instruction (0 = first fetch cycle).
  function automatic logic [14:0] exp_vec(input logic [3:0] op, input logic zf, input int idx);
    case (idx)
      0: return PC_OUT | MAR_LOAD;
      1: return MEM_OUT | IR_LOAD | PC_INC;
      2: case (op)
           4'h1, 4'h2, 4'h3, 4'h4: return IR_OUT | MAR_LOAD;
           4'h5: return IR_OUT | ACC_LW;
           4'h6: return IR_OUT | PC_LOAD;
           4'h7: return zf ? (IR_OUT | PC_LOAD) : IR_OUT;
           4'hE: return ACC_OUT | OUT_LOAD;
           default: return 15'h0;
         endcase
      3: case (op)
           4'h1: return MEM_OUT | ACC_W;
           4'h2, 4'h3: return MEM_OUT | B_LOAD;
           4'h4: return ACC_OUT | MEM_WRITE;
           default: return 15'h0;
         endcase
      4: return ALU_OUT | ACC_W | ((op == 4'h3) ? ALU_SUB : 15'h0);
      default: return 15'h0;
    endcase
  endfunction

  task automatic set_in(input logic [3:0] op, input logic zf, input logic r, input logic rs);
    @(negedge clk);
    ir_opcode = op;
    zero_flag = zf;
    run = r;
    rst = rs;
    #1;
  endtask

  task automatic test_reset;
    logic [14:0] e;
    for (int c = 0; c < 2; c++) begin
      set_in(4'($urandom), 1'($urandom), 1'b1, 1'b1);
      checks++;
      if (obs !== 15'h0 || halted !== 1'b0) begin
        failures++;
        $display("FAIL reset_cyc%0d: strobes=%h halted=%b, want 0 0", c, obs, halted);
      end
    end
    for (int idx = 0; idx < 3; idx++) begin
      set_in(4'h0, 1'b0, 1'b1, 1'b0);
      e = exp_vec(4'h0, 1'b0, idx);
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL reset_release_idx%0d: strobes=%h want %h", idx, obs, e);
      end
`ifdef SAP_CTRL_INSTR_COUNT_EN
      if (idx == 0) begin
        checks++;
        if (instr_count !== 16'd0) begin
          failures++;
          $display("FAIL reset_count: instr_count=%0d want 0", instr_count);
        end
      end
`endif
    end
  endtask

  task automatic test_add;
    logic zf;
    logic [14:0] e;
    for (int idx = 0; idx < exp_len(4'h2); idx++) begin
      zf = 1'($urandom);
      set_in(4'h2, zf, 1'b1, 1'b0);
      e = exp_vec(4'h2, zf, idx);
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL add_idx%0d: strobes=%h want %h", idx, obs, e);
      end
    end
  endtask

  task automatic test_ldi_jz;
    logic [3:0] ops [3] = '{4'h5, 4'h7, 4'h7};
    logic zfs [3] = '{1'b0, 1'b0, 1'b1};
    logic [14:0] e;
    for (int k = 0; k < 3; k++) begin
      for (int idx = 0; idx < exp_len(ops[k]); idx++) begin
        set_in(ops[k], zfs[k], 1'b1, 1'b0);
        e = exp_vec(ops[k], zfs[k], idx);
        checks++;
        if (obs !== e) begin
          failures++;
          $display("FAIL ldi_jz_op%h_zf%b_idx%0d: strobes=%h want %h", ops[k], zfs[k], idx, obs, e);
        end
      end
    end
  endtask

  task automatic test_stall;
    logic [14:0] e;
    for (int idx = 0; idx < 3; idx++) begin
      set_in(4'h1, 1'b0, 1'b1, 1'b0);
      e = exp_vec(4'h1, 1'b0, idx);
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL stall_pre_idx%0d: strobes=%h want %h", idx, obs, e);
      end
    end
    for (int c = 0; c < 3; c++) begin
      set_in(4'h1, 1'($urandom), 1'b0, 1'b0);
      checks++;
      if (obs !== 15'h0 || halted !== 1'b0) begin
        failures++;
        $display("FAIL stall_hold%0d: strobes=%h halted=%b want 0 0", c, obs, halted);
      end
    end
    set_in(4'h1, 1'b0, 1'b1, 1'b0);
    e = exp_vec(4'h1, 1'b0, 3);
    checks++;
    if (obs !== e) begin
      failures++;
      $display("FAIL stall_resume: strobes=%h want %h", obs, e);
    end
  endtask

  task automatic test_halt;
    logic [14:0] e;
    for (int idx = 0; idx < exp_len(4'hF); idx++) begin
      set_in(4'hF, 1'b0, 1'b1, 1'b0);
      e = exp_vec(4'hF, 1'b0, idx);
      checks++;
      if (obs !== e || halted !== 1'b0) begin
        failures++;
        $display("FAIL hlt_idx%0d: strobes=%h halted=%b want %h 0", idx, obs, halted, e);
      end
    end
    for (int c = 0; c < 20; c++) begin
      set_in(4'($urandom), 1'($urandom), (c % 4 == 3) ? 1'b0 : 1'b1, 1'b0);
      checks++;
      if (obs !== 15'h0 || halted !== 1'b1) begin
        failures++;
        $display("FAIL halt_hold%0d: strobes=%h halted=%b want 0 1", c, obs, halted);
      end
    end
    set_in(4'h0, 1'b0, 1'b1, 1'b1);
    checks++;
    if (obs !== 15'h0) begin
      failures++;
      $display("FAIL halt_rst: strobes=%h want 0", obs);
    end
    set_in(4'h0, 1'b0, 1'b1, 1'b0);
    e = exp_vec(4'h0, 1'b0, 0);
    checks++;
    if (obs !== e || halted !== 1'b0) begin
      failures++;
      $display("FAIL halt_exit: strobes=%h halted=%b want %h 0", obs, halted, e);
    end
  endtask

  task automatic test_random;
    logic [3:0] op;
    logic zf;
    logic [14:0] e;
    int n_done;
    set_in(4'h0, 1'b0, 1'b1, 1'b1);
    checks++;
    if (obs !== 15'h0) begin
      failures++;
      $display("FAIL rand_rst: strobes=%h want 0", obs);
    end
    n_done = 0;
    for (int k = 0; k < 60; k++) begin
      op = 4'($urandom_range(0, 14));
      for (int idx = 0; idx < exp_len(op); idx++) begin
        while ($urandom_range(0, 5) == 0) begin
          set_in((idx < 2) ? 4'($urandom) : op, 1'($urandom), 1'b0, 1'b0);
          checks++;
          if (obs !== 15'h0) begin
            failures++;
            $display("FAIL rand_stall_op%h_idx%0d: strobes=%h want 0", op, idx, obs);
          end
        end
        zf = 1'($urandom);
        set_in((idx < 2) ? 4'($urandom) : op, zf, 1'b1, 1'b0);
        e = exp_vec(op, zf, idx);
        checks++;
        if (obs !== e) begin
          failures++;
          $display("FAIL rand_op%h_zf%b_idx%0d: strobes=%h want %h", op, zf, idx, obs, e);
        end
        checks++;
        if ($countones(obs & BUS_MASK) > 1 || (acc_write && acc_lower_write)) begin
          failures++;
          $display("FAIL rand_exclusive_op%h_idx%0d: strobes=%h want bus one-hot-or-zero", op, idx, obs);
        end
`ifdef SAP_CTRL_INSTR_COUNT_EN
        if (idx == 0) begin
          checks++;
          if (instr_count !== 16'(n_done)) begin
            failures++;
            $display("FAIL rand_count: instr_count=%0d want %0d", instr_count, n_done);
          end
        end
`endif
      end
      n_done++;
    end
`ifdef SAP_CTRL_INSTR_COUNT_EN
    set_in(4'h0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (instr_count !== 16'(n_done)) begin
      failures++;
      $display("FAIL rand_count_final: instr_count=%0d want %0d", instr_count, n_done);
    end
`endif
  endtask

  initial begin
    test_reset;
    test_add;
    test_ldi_jz;
    test_stall;
    test_halt;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
